// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave in front of a word-organised RAM with byte strobes.
// Write address and data are held independently and commit together; reads take one fetch cycle.
module axi_lite_ram_slave #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  localparam int unsigned     IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(MEM_WORDS) << 2;
  localparam logic [1:0]      RESP_OKAY = 2'b00;
  localparam logic [1:0]      RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  logic              aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_W-1:0] aw_addr, aw_addr_n;
  logic [31:0]       w_data, w_data_n;
  logic [3:0]        w_strb, w_strb_n;
  logic              awready, awready_n, wready, wready_n;
  logic              bvalid, bvalid_n;
  logic [1:0]        bresp, bresp_n;
  logic              commit;

  r_state_t          r_state, r_state_n;
  logic [ADDR_W-1:0] ar_addr, ar_addr_n;
  logic              arready, arready_n, rvalid, rvalid_n;
  logic [31:0]       rdata, rdata_n;
  logic [1:0]        rresp, rresp_n;

  // Offsets wrap modulo 2^ADDR_W, so a window that wraps past the top still decodes correctly.
  logic [ADDR_W-1:0] aw_off, ar_off;
  logic              aw_in_win, ar_in_win;
  logic [IDX_W-1:0]  aw_idx, ar_idx;

  assign aw_off    = aw_addr - BASE_ADDR;
  assign ar_off    = ar_addr - BASE_ADDR;
  assign aw_in_win = {1'b0, aw_off} < WIN_BYTES;
  assign ar_in_win = {1'b0, ar_off} < WIN_BYTES;
  assign aw_idx    = aw_off[IDX_W+1:2];
  assign ar_idx    = ar_off[IDX_W+1:2];
  assign commit    = aw_held && w_held;

  always_comb begin
    aw_held_n = aw_held;
    aw_addr_n = aw_addr;
    w_held_n  = w_held;
    w_data_n  = w_data;
    w_strb_n  = w_strb;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
      bresp_n   = aw_in_win ? RESP_OKAY : RESP_SLV;
    end else begin
      if (S_AXI_AWVALID && awready) begin
        aw_held_n = 1'b1;
        aw_addr_n = S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && wready) begin
        w_held_n = 1'b1;
        w_data_n = S_AXI_WDATA;
        w_strb_n = S_AXI_WSTRB;
      end
      if (bvalid && S_AXI_BREADY) bvalid_n = 1'b0;
    end
    awready_n = !aw_held_n && !bvalid_n;
    wready_n  = !w_held_n && !bvalid_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
    end else begin
      aw_held <= aw_held_n;
      aw_addr <= aw_addr_n;
      w_held  <= w_held_n;
      w_data  <= w_data_n;
      w_strb  <= w_strb_n;
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
    end
  end

  // RAM has no reset; a read fetching on the commit edge sees the old word.
  always_ff @(posedge clk) begin
    if (commit && aw_in_win) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    r_state_n = r_state;
    ar_addr_n = ar_addr;
    arready_n = arready;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (S_AXI_ARVALID && arready) begin
          ar_addr_n = S_AXI_ARADDR;
          arready_n = 1'b0;
          r_state_n = R_FETCH;
        end
      end
      R_FETCH: begin
        rvalid_n  = 1'b1;
        r_state_n = R_RESP;
        if (ar_in_win) begin
          rdata_n = mem[ar_idx];
          rresp_n = RESP_OKAY;
        end else begin
          rdata_n = '0;
          rresp_n = RESP_SLV;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      ar_addr <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      r_state <= r_state_n;
      ar_addr <= ar_addr_n;
      arready <= arready_n;
      rvalid  <= rvalid_n;
      rdata   <= rdata_n;
      rresp   <= rresp_n;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave: a default 1024-word instance and a small
// instance at base 0x1000 (16 words) for window-decode cases.
module tb_axi_lite_ram_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [31:0] araddr [2];
  logic [3:0]  wstrb  [2];
  logic        awvalid [2];
  logic        wvalid  [2];
  logic        bready  [2];
  logic        arvalid [2];
  logic        rready  [2];
  wire         awready [2];
  wire         wready  [2];
  wire         bvalid  [2];
  wire         arready [2];
  wire         rvalid  [2];
  wire [1:0]   bresp   [2];
  wire [1:0]   rresp   [2];
  wire [31:0]  rdata   [2];

  int errors = 0;
  int checks = 0;

  axi_lite_ram_slave #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .MEM_WORDS(1024)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWVALID(awvalid[0]), .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]), .S_AXI_WVALID(wvalid[0]), .S_AXI_WREADY(wready[0]),
    .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready[0]),
    .S_AXI_ARADDR(araddr[0]), .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready[0])
  );

  axi_lite_ram_slave #(.ADDR_W(32), .BASE_ADDR(32'h0000_1000), .MEM_WORDS(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWVALID(awvalid[1]), .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]), .S_AXI_WVALID(wvalid[1]), .S_AXI_WREADY(wready[1]),
    .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready[1]),
    .S_AXI_ARADDR(araddr[1]), .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with AW and W presented together; returns BRESP.
  task automatic applyStimulus(input int s, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    awaddr[s] = a; wdata[s] = d; wstrb[s] = st;
    awvalid[s] = 1'b1; wvalid[s] = 1'b1;
    n = 0;
    while ((awvalid[s] || wvalid[s]) && n < 20) begin
      aw_hs = awvalid[s] && awready[s];
      w_hs  = wvalid[s] && wready[s];
      step();
      n++;
      if (aw_hs) awvalid[s] = 1'b0;
      if (w_hs) wvalid[s] = 1'b0;
    end
    checkOutput("write_handshake", {30'd0, awvalid[s], wvalid[s]}, 32'd0);
    awvalid[s] = 1'b0; wvalid[s] = 1'b0;
    n = 0;
    while (!bvalid[s] && n < 20) begin
      step();
      n++;
    end
    checkOutput("write_bvalid", {31'd0, bvalid[s]}, 32'd1);
    resp = bresp[s];
    bready[s] = 1'b1;
    step();
    bready[s] = 1'b0;
  endtask

  task automatic readWord(input int s, input logic [31:0] a,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic ar_hs;
    araddr[s] = a; arvalid[s] = 1'b1;
    n = 0;
    while (arvalid[s] && n < 20) begin
      ar_hs = arready[s];
      step();
      n++;
      if (ar_hs) arvalid[s] = 1'b0;
    end
    arvalid[s] = 1'b0;
    n = 0;
    while (!rvalid[s] && n < 20) begin
      step();
      n++;
    end
    checkOutput("read_rvalid", {31'd0, rvalid[s]}, 32'd1);
    data = rdata[s];
    resp = rresp[s];
    rready[s] = 1'b1;
    step();
    rready[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; wdata[i] = '0; araddr[i] = '0; wstrb[i] = '0;
      awvalid[i] = 1'b0; wvalid[i] = 1'b0; bready[i] = 1'b0;
      arvalid[i] = 1'b0; rready[i] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("reset_flags", {23'd0, awready[0], wready[0], bvalid[0], arready[0], rvalid[0],
                                bresp[0], rresp[0]}, 32'd0);
    checkOutput("reset_rdata", rdata[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkOutput("first_edge_readys", {29'd0, awready[0], wready[0], arready[0]}, 32'h7);

    // Simultaneous AW/W: BVALID one edge after the handshake edge
    awaddr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    checkOutput("t1_ready_drop", {30'd0, awready[0], wready[0]}, 32'd0);
    checkOutput("t1_bvalid_early", {31'd0, bvalid[0]}, 32'd0);
    step();
    checkOutput("t1_bvalid", {31'd0, bvalid[0]}, 32'd1);
    checkOutput("t1_bresp", {30'd0, bresp[0]}, 32'd0);
    bready[0] = 1'b1;
    step();
    bready[0] = 1'b0;
    checkOutput("t1_after_b", {29'd0, bvalid[0], awready[0], wready[0]}, 32'd3);
    araddr[0] = 32'h10; arvalid[0] = 1'b1;
    step();
    arvalid[0] = 1'b0;
    checkOutput("t1_fetch", {30'd0, arready[0], rvalid[0]}, 32'd0);
    step();
    checkOutput("t1_rvalid", {31'd0, rvalid[0]}, 32'd1);
    checkOutput("t1_rdata", rdata[0], 32'hDEADBEEF);
    checkOutput("t1_rresp", {30'd0, rresp[0]}, 32'd0);
    rready[0] = 1'b1;
    step();
    rready[0] = 1'b0;
    checkOutput("t1_after_r", {30'd0, rvalid[0], arready[0]}, 32'd1);

    // Byte strobes
    applyStimulus(0, 32'h20, 32'h11223344, 4'hF, resp);
    applyStimulus(0, 32'h20, 32'hAABBCCDD, 4'b0101, resp);
    checkOutput("t2_bresp", {30'd0, resp}, 32'd0);
    readWord(0, 32'h20, data, resp);
    checkOutput("t2_strb_data", data, 32'h11BB33DD);
    applyStimulus(0, 32'h20, 32'hFFFFFFFF, 4'b0000, resp);
    checkOutput("t2_zero_strb_bresp", {30'd0, resp}, 32'd0);
    readWord(0, 32'h22, data, resp);
    checkOutput("t2_zero_strb_data", data, 32'h11BB33DD);

    // W three cycles ahead of AW, BREADY held low
    wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    step();
    wvalid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_w_only", {30'd0, awready[0], wready[0]}, 32'd2);
      if (i < 2) step();
    end
    awaddr[0] = 32'h30; awvalid[0] = 1'b1;
    step();
    awvalid[0] = 1'b0;
    checkOutput("t3_aw_taken", {29'd0, awready[0], wready[0], bvalid[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t3_b_hold", {27'd0, bvalid[0], bresp[0], awready[0], wready[0]}, 32'h10);
    end
    bready[0] = 1'b1;
    step();
    bready[0] = 1'b0;
    checkOutput("t3_after_b", {29'd0, bvalid[0], awready[0], wready[0]}, 32'd3);
    readWord(0, 32'h30, data, resp);
    checkOutput("t3_data", data, 32'hCAFEF00D);

    // Window decode on the 0x1000/16-word instance
    applyStimulus(1, 32'h1000, 32'h5A5A5A5A, 4'hF, resp);
    checkOutput("t4_in_bresp", {30'd0, resp}, 32'd0);
    applyStimulus(1, 32'h103C, 32'h0BADCAFE, 4'hF, resp);
    applyStimulus(1, 32'h1040, 32'h12345678, 4'hF, resp);
    checkOutput("t4_oor_bresp", {30'd0, resp}, 32'd2);
    readWord(1, 32'h1002, data, resp);
    checkOutput("t4_word0_data", data, 32'h5A5A5A5A);
    checkOutput("t4_word0_rresp", {30'd0, resp}, 32'd0);
    readWord(1, 32'h103C, data, resp);
    checkOutput("t4_top_word", data, 32'h0BADCAFE);
    readWord(1, 32'h0FFC, data, resp);
    checkOutput("t4_below_rresp", {30'd0, resp}, 32'd2);
    checkOutput("t4_below_rdata", data, 32'd0);
    readWord(1, 32'h1042, data, resp);
    checkOutput("t4_above_rresp", {30'd0, resp}, 32'd2);
    checkOutput("t4_above_rdata", data, 32'd0);

    // Read fetching on the commit edge sees old data
    applyStimulus(0, 32'h8, 32'h0000AAAA, 4'hF, resp);
    awaddr[0] = 32'h8; wdata[0] = 32'h0000BBBB; wstrb[0] = 4'hF; araddr[0] = 32'h8;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    checkOutput("t5_all_taken", {29'd0, awready[0], wready[0], arready[0]}, 32'd0);
    step();
    checkOutput("t5_both_valid", {30'd0, bvalid[0], rvalid[0]}, 32'd3);
    checkOutput("t5_old_data", rdata[0], 32'h0000AAAA);
    bready[0] = 1'b1; rready[0] = 1'b1;
    step();
    bready[0] = 1'b0; rready[0] = 1'b0;
    readWord(0, 32'h8, data, resp);
    checkOutput("t5_new_data", data, 32'h0000BBBB);

    // Reset with only the address held
    applyStimulus(0, 32'h40, 32'h01020304, 4'hF, resp);
    awaddr[0] = 32'h40; awvalid[0] = 1'b1;
    step();
    awvalid[0] = 1'b0;
    checkOutput("t6_aw_held", {30'd0, awready[0], wready[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_flags", {23'd0, awready[0], wready[0], bvalid[0], arready[0], rvalid[0],
                                 bresp[0], rresp[0]}, 32'd0);
    checkOutput("t6_rst_rdata", rdata[0], 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkOutput("t6_readys", {29'd0, awready[0], wready[0], arready[0]}, 32'h7);
    applyStimulus(0, 32'h44, 32'h77777777, 4'hF, resp);
    checkOutput("t6_fresh_bresp", {30'd0, resp}, 32'd0);
    readWord(0, 32'h40, data, resp);
    checkOutput("t6_word_kept", data, 32'h01020304);
    readWord(0, 32'h44, data, resp);
    checkOutput("t6_fresh_data", data, 32'h77777777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
